truth_table_sweeper: RTL and testbench
======================================

// Module: truth_table_sweeper
// PURPOSE
//   Parametrised, synthesisable exhaustive-stimulus engine for N-input, 1-output combinational DUTs.
//   Drives every input pattern 0..2^N_IN-1 in ascending order and holds each for HOLD clocks.
//   Samples the DUT output on the last held cycle and compares it against a supplied truth table.
//   Reports the mismatch count, the first failing pattern and pass/done status.
//   Used in lab benches and on-board self-test, in place of hand-written per-pattern delays.
// PARAMETERS
//   N_IN   3   number of DUT inputs (1..8); the sweep has 2^N_IN patterns
//   HOLD   20  clocks each pattern is held (>=2); the DUT output is sampled on the last one
// PORTS
//   clk          in   1          rising-edge clock
//   rst          in   1          synchronous reset, active-high
//   start        in   1          begin a sweep; sampled only in IDLE
//   stop         in   1          abort the sweep; sampled only in RUN
//   mode         in   1          0 = single sweep, 1 = continuous (wrap and repeat)
//   expect_tt    in   2^N_IN     expected output; bit i is the expected value for pattern i
//   dut_out      in   1          DUT response
//   dut_in       out  N_IN       pattern currently driven to the DUT
//   busy         out  1          high in RUN
//   done         out  1          one-cycle pulse at the end of a sweep or on abort
//   pass         out  1          high when the last completed sweep had zero mismatches
//   err_count    out  N_IN+1     accumulated mismatches; saturates at all-ones
//   fail_valid   out  1          high when at least one mismatch has been recorded
//   first_fail   out  N_IN       pattern index of the first mismatch
// BEHAVIOUR
//   Reset values: all outputs 0, state = IDLE. A reset in any state, including mid-RUN,
//     returns to IDLE on the next edge; no done pulse is produced.
//   States: IDLE -> RUN -> FIN -> IDLE.
//   IDLE: dut_in holds its last value; pass, err_count and fail stats hold their last values.
//     - start=1 at edge k: go to RUN at k+1; clear err_count, fail_valid and first_fail.
//     - Also at k+1: pattern index idx=0, hold counter hc=0, latch mode, busy=1.
//   RUN: dut_in = idx; hc counts 0..HOLD-1.
//     - Pattern i occupies cycles k+1+i*HOLD .. k+(i+1)*HOLD.
//     - Sample on the cycle where hc==HOLD-1:
//       - mismatch = dut_out ^ expect_tt[idx];
//       - err_count += mismatch, saturating;
//       - on the first mismatch of the sweep, first_fail <= idx and fail_valid <= 1.
//     - Advance: hc resets and idx increments; the sample and the advance happen on the same edge.
//     - Last pattern (idx = 2^N_IN-1), mode=0: go to FIN.
//     - Last pattern, mode=1: idx wraps to 0 and RUN continues; err_count and fail stats keep accumulating.
//     - expect_tt is read live, so a change takes effect from the next sample.
//   FIN: lasts one cycle, then IDLE. done=1, busy=0, pass = (err_count==0), using the count that
//     includes the final sample.
//     - Single sweep: done is asserted at k+1+2^N_IN*HOLD.
//   stop=1 in RUN: go to FIN on the next edge.
//     - A sample on that same edge is still taken.
//     - pass=0 on abort, regardless of errors.
//   start is ignored when not in IDLE. stop is ignored outside RUN.
//   If stop and a last-pattern advance coincide, the result is FIN; a pass is reported only if the sweep completed.
//   Width: idx and first_fail are N_IN bits and wrap naturally. The hc width is clog2(HOLD).
// TESTING  (N_IN=3, HOLD=4 unless noted)
//   1 Majority DUT, expect_tt=8'hE8, start at k -> dut_in steps 0..7 every 4 clk;
//     done at k+33; pass=1, err_count=0, fail_valid=0.
//   2 Same DUT, expect_tt=8'hE9 -> pass=0, err_count=1, first_fail=0; a second sweep clears
//     the stats before counting again.
//   3 Stuck-at-1 DUT, expect_tt=8'h00 -> err_count=8, first_fail=0; mode=1 for 5 sweeps ->
//     err_count saturates at 4'hF, done is never pulsed until stop.
//   4 stop asserted at pattern 3, hc=1 -> done one cycle later, busy=0, pass=0, err_count frozen.
//   5 rst pulsed mid-RUN -> next cycle all outputs 0, IDLE, no done;
//     start during RUN is ignored (dut_in sequence unchanged).
//   6 N_IN=1, HOLD=2, inverter DUT, expect_tt=2'b01 -> done at k+5, pass=1.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// Exhaustive-stimulus engine: walks every N_IN-bit input pattern, holds each for HOLD
// clocks, samples the DUT on the last held cycle and checks it against a truth table.
module truth_table_sweeper #(
  parameter int N_IN = 3,
  parameter int HOLD = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  mode,
  input  logic [(1<<N_IN)-1:0]  expect_tt,
  input  logic                  dut_out,
  output logic [N_IN-1:0]       dut_in,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [N_IN:0]         err_count,
  output logic                  fail_valid,
  output logic [N_IN-1:0]       first_fail
);

  localparam int HC_W = $clog2(HOLD);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [N_IN-1:0] idx_q, idx_d;
  logic [HC_W-1:0] hc_q, hc_d;
  logic            mode_q, mode_d;
  logic            pass_q, pass_d;
  logic [N_IN:0]   err_count_q, err_count_d;
  logic            fail_valid_q, fail_valid_d;
  logic [N_IN-1:0] first_fail_q, first_fail_d;

  logic sample;
  logic last_pat;
  logic mismatch;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    hc_d         = hc_q;
    mode_d       = mode_q;
    pass_d       = pass_q;
    err_count_d  = err_count_q;
    fail_valid_d = fail_valid_q;
    first_fail_d = first_fail_q;

    sample   = (state_q == ST_RUN) && (hc_q == HC_W'(HOLD - 1));
    last_pat = &idx_q;
    mismatch = dut_out ^ expect_tt[idx_q];

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d      = ST_RUN;
          idx_d        = '0;
          hc_d         = '0;
          mode_d       = mode;
          err_count_d  = '0;
          fail_valid_d = 1'b0;
          first_fail_d = '0;
        end
      end
      ST_RUN: begin
        if (sample) begin
          if (mismatch) begin
            if (!(&err_count_q)) err_count_d = err_count_q + 1'b1;
            if (!fail_valid_q) begin
              first_fail_d = idx_q;
              fail_valid_d = 1'b1;
            end
          end
          hc_d = '0;
          if (last_pat && !mode_q) begin
            state_d = ST_FIN;
            pass_d  = (err_count_d == '0);
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          hc_d = hc_q + 1'b1;
        end
        // An abort only reports a pass if the final pattern was sampled on this same edge.
        if (stop) begin
          state_d = ST_FIN;
          pass_d  = (sample && last_pat) ? (err_count_d == '0) : 1'b0;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      hc_q         <= '0;
      mode_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_count_q  <= '0;
      fail_valid_q <= 1'b0;
      first_fail_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      hc_q         <= hc_d;
      mode_q       <= mode_d;
      pass_q       <= pass_d;
      err_count_q  <= err_count_d;
      fail_valid_q <= fail_valid_d;
      first_fail_q <= first_fail_d;
    end
  end

  assign dut_in     = idx_q;
  assign busy       = (state_q == ST_RUN);
  assign done       = (state_q == ST_FIN);
  assign pass       = pass_q;
  assign err_count  = err_count_q;
  assign fail_valid = fail_valid_q;
  assign first_fail = first_fail_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: a 3-input/HOLD=4 instance driving majority or
// stuck-at-1 models, plus a 1-input/HOLD=2 instance driving an inverter.
module tb_truth_table_sweeper;

  logic       clk;
  logic       rst;
  logic       start, stop, mode;
  logic [7:0] expect_tt;
  logic       dut_out;
  logic [2:0] dut_in;
  logic       busy, done, pass;
  logic [3:0] err_count;
  logic       fail_valid;
  logic [2:0] first_fail;
  logic       dut_kind;

  logic       start1, stop1, mode1;
  logic [1:0] expect1;
  logic       dut_out1;
  logic [0:0] dut_in1;
  logic       busy1, done1, pass1;
  logic [1:0] err_count1;
  logic       fail_valid1;
  logic [0:0] first_fail1;

  int total = 0;
  int bad   = 0;

  truth_table_sweeper #(.N_IN(3), .HOLD(4)) u_dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
    .expect_tt(expect_tt), .dut_out(dut_out), .dut_in(dut_in),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_valid(fail_valid), .first_fail(first_fail)
  );

  truth_table_sweeper #(.N_IN(1), .HOLD(2)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .stop(stop1), .mode(mode1),
    .expect_tt(expect1), .dut_out(dut_out1), .dut_in(dut_in1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err_count1),
    .fail_valid(fail_valid1), .first_fail(first_fail1)
  );

  // Device models: 0 = 3-input majority, 1 = stuck-at-1; second instance is an inverter.
  always_comb begin
    dut_out  = dut_kind ? 1'b1
             : ((dut_in[0] & dut_in[1]) | (dut_in[0] & dut_in[2]) | (dut_in[1] & dut_in[2]));
    dut_out1 = ~dut_in1[0];
  end

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Walks n RUN cycles starting at cycle offset base of the sweep, checking the driven pattern.
  task automatic run_checked(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      check("dut_in_seq", {29'd0, dut_in}, ((base + i) / 4) % 8);
      check("busy_run", {31'd0, busy}, 1);
      check("done_low", {31'd0, done}, 0);
      tick();
    end
  endtask

  task automatic start_sweep(input logic [7:0] tt, input logic m);
    expect_tt = tt;
    mode      = m;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0; expect_tt = 8'h00; dut_kind = 1'b0;
    start1 = 1'b0; stop1 = 1'b0; mode1 = 1'b0; expect1 = 2'b01;
    tick(); tick();
    rst = 1'b0;

    check("rst_dut_in", {29'd0, dut_in}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_pass", {31'd0, pass}, 0);
    check("rst_err", {28'd0, err_count}, 0);
    check("rst_fv", {31'd0, fail_valid}, 0);
    check("rst_ff", {29'd0, first_fail}, 0);

    // 1: majority, correct table
    start_sweep(8'hE8, 1'b0);
    run_checked(0, 32);
    check("t1_done", {31'd0, done}, 1);
    check("t1_busy", {31'd0, busy}, 0);
    check("t1_pass", {31'd0, pass}, 1);
    check("t1_err", {28'd0, err_count}, 0);
    check("t1_fv", {31'd0, fail_valid}, 0);
    tick();
    check("t1_done_pulse", {31'd0, done}, 0);

    // 2: majority, table wrong at pattern 0; second sweep restarts the count
    start_sweep(8'hE9, 1'b0);
    run_checked(0, 32);
    check("t2_done", {31'd0, done}, 1);
    check("t2_pass", {31'd0, pass}, 0);
    check("t2_err", {28'd0, err_count}, 1);
    check("t2_ff", {29'd0, first_fail}, 0);
    check("t2_fv", {31'd0, fail_valid}, 1);
    tick();
    start_sweep(8'hE9, 1'b0);
    check("t2_clr_err", {28'd0, err_count}, 0);
    check("t2_clr_fv", {31'd0, fail_valid}, 0);
    run_checked(0, 32);
    check("t2b_err", {28'd0, err_count}, 1);
    tick();

    // 3: stuck-at-1 against all-zero table, then continuous saturation
    dut_kind = 1'b1;
    start_sweep(8'h00, 1'b0);
    run_checked(0, 32);
    check("t3_err", {28'd0, err_count}, 8);
    check("t3_ff", {29'd0, first_fail}, 0);
    check("t3_pass", {31'd0, pass}, 0);
    tick();
    start_sweep(8'h00, 1'b1);
    run_checked(0, 160);
    check("t3_sat", {28'd0, err_count}, 4'hF);
    check("t3_cont_busy", {31'd0, busy}, 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("t3_stop_done", {31'd0, done}, 1);
    check("t3_stop_pass", {31'd0, pass}, 0);
    check("t3_stop_err", {28'd0, err_count}, 4'hF);
    tick();
    dut_kind = 1'b0;

    // 4: abort at pattern 3, hc=1, after a passing sweep
    start_sweep(8'hE8, 1'b0);
    run_checked(0, 32);
    check("t4_pre_pass", {31'd0, pass}, 1);
    tick();
    start_sweep(8'hE9, 1'b0);
    run_checked(0, 13);
    check("t4_at_p3", {29'd0, dut_in}, 3);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("t4_done", {31'd0, done}, 1);
    check("t4_busy", {31'd0, busy}, 0);
    check("t4_pass", {31'd0, pass}, 0);
    check("t4_err", {28'd0, err_count}, 1);
    tick();
    check("t4_err_frozen", {28'd0, err_count}, 1);
    check("t4_done_pulse", {31'd0, done}, 0);

    // stop coinciding with the final sample still reports a pass
    start_sweep(8'hE8, 1'b0);
    run_checked(0, 31);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("t4b_done", {31'd0, done}, 1);
    check("t4b_pass", {31'd0, pass}, 1);
    tick();

    // 5: start during RUN ignored, then reset mid-RUN
    start_sweep(8'hE9, 1'b0);
    run_checked(0, 6);
    start = 1'b1;
    run_checked(6, 1);
    start = 1'b0;
    run_checked(7, 5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_dut_in", {29'd0, dut_in}, 0);
    check("t5_busy", {31'd0, busy}, 0);
    check("t5_done", {31'd0, done}, 0);
    check("t5_err", {28'd0, err_count}, 0);
    check("t5_fv", {31'd0, fail_valid}, 0);
    tick();
    check("t5_idle_busy", {31'd0, busy}, 0);
    check("t5_idle_done", {31'd0, done}, 0);

    // 6: 1-input inverter, HOLD=2
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("t6_dut_in", {31'd0, dut_in1}, i / 2);
      check("t6_done_low", {31'd0, done1}, 0);
      tick();
    end
    check("t6_done", {31'd0, done1}, 1);
    check("t6_pass", {31'd0, pass1}, 1);
    check("t6_err", {30'd0, err_count1}, 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
